secded_decoder: RTL and testbench

- Pipelined extended-Hamming (SECDED) decoder; the receive-side counterpart of the two-stage encoder.
- Accepts 32-bit zero-padded codewords in three modes: (8,4), (16,11) and (32,26).
- Computes the syndrome and the overall parity, corrects single errors, flags double errors, and extracts right-justified info bits.
- Keeps saturating error-event counters for the status/CSR layer.

---
 rtl/secded_decoder_if.sv | 33 +++
 rtl/secded_decoder.sv | 203 ++++++++++++++++++++
 tb/tb_secded_decoder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/secded_decoder_if.sv
// Bus bundle for the SECDED decoder: receive side, decoded outputs and counters.
//
// Handshake: in_valid qualifies codeword_in/work_mod in the cycle it is high.
// The decoder has no ready and never stalls, so it accepts one word every cycle.
// out_valid is in_valid delayed by exactly two cycles. When out_valid is low,
// the data outputs keep the last value that was presented.
interface secded_decoder_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 in_valid;
  logic [31:0]          codeword_in;
  logic [1:0]           work_mod;
  logic                 cnt_clr;
  logic                 out_valid;
  logic [25:0]          info_out;
  logic [31:0]          codeword_out;
  logic [1:0]           status;
  logic [5:0]           err_pos;
  logic [CNT_WIDTH-1:0] corr_cnt;
  logic [CNT_WIDTH-1:0] uncorr_cnt;

  // Traffic source (bench or upstream logic).
  modport master (
    output in_valid, codeword_in, work_mod, cnt_clr,
    input  out_valid, info_out, codeword_out, status, err_pos, corr_cnt, uncorr_cnt
  );

  // Decoder side.
  modport slave (
    input  in_valid, codeword_in, work_mod, cnt_clr,
    output out_valid, info_out, codeword_out, status, err_pos, corr_cnt, uncorr_cnt
  );
endinterface

// File: rtl/secded_decoder.sv
// Two-stage extended-Hamming (SECDED) decoder for (8,4), (16,11) and (32,26).
// Stage 1 registers the masked word plus its syndrome and overall parity.
// Stage 2 corrects or flags the word, extracts the info bits and updates
// the saturating error counters.
module secded_decoder #(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_INFO_WIDTH     = 26,
  parameter int CNT_WIDTH          = 16
) (
  input  logic             clk,
  input  logic             rst,
  secded_decoder_if.slave  bus
);

  // Syndrome row k for a mode. Rows are zero above n-1, so narrower modes
  // give a zero-extended syndrome.
  function automatic logic [31:0] row_of(input logic [1:0] mode, input logic [2:0] k);
    logic [31:0] r;
    r = 32'h0;
    case ({mode, k})
      5'b00_000: r = 32'h0000_00B1;
      5'b00_001: r = 32'h0000_00D2;
      5'b00_010: r = 32'h0000_00E4;
      5'b01_000: r = 32'h0000_AB61;
      5'b01_001: r = 32'h0000_CDA2;
      5'b01_010: r = 32'h0000_F1C4;
      5'b01_011: r = 32'h0000_FE08;
      5'b10_000: r = 32'hAAAB_56C1;
      5'b10_001: r = 32'hCCCD_9B42;
      5'b10_010: r = 32'hF0F1_E384;
      5'b10_011: r = 32'hFF01_FC08;
      5'b10_100: r = 32'hFFFE_0010;
      default:   r = 32'h0;
    endcase
    return r;
  endfunction

  // Syndrome column of codeword bit j.
  function automatic logic [4:0] col_of(input logic [1:0] mode, input int j);
    logic [4:0]  c;
    logic [31:0] r;
    c = 5'd0;
    for (int k = 0; k < 5; k++) begin
      r    = row_of(mode, 3'(k));
      c[k] = r[j];
    end
    return c;
  endfunction

  // Mask selecting the n live bits; the invalid mode keeps nothing.
  function automatic logic [31:0] mask_of(input logic [1:0] mode);
    case (mode)
      2'b00:   return 32'h0000_00FF;
      2'b01:   return 32'h0000_FFFF;
      2'b10:   return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  // Stage 1 combinational: mask, syndrome, overall parity
  logic [31:0] w_cw_masked;
  logic [4:0]  w_syn;
  logic        w_par;

  // Syndrome and parity over the live bits of the incoming word
  always_comb begin
    w_cw_masked = bus.codeword_in & mask_of(bus.work_mod);
    w_syn       = 5'd0;
    for (int k = 0; k < 5; k++) begin
      w_syn[k] = ^(row_of(bus.work_mod, 3'(k)) & w_cw_masked);
    end
    w_par = ^w_cw_masked;
  end

  logic        r_s1_valid;
  logic [31:0] r_s1_cw;
  logic [1:0]  r_s1_mode;
  logic [4:0]  r_s1_syn;
  logic        r_s1_par;

  // Stage 1 registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_cw    <= 32'h0;
      r_s1_mode  <= 2'b00;
      r_s1_syn   <= 5'd0;
      r_s1_par   <= 1'b0;
    end else begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_cw   <= w_cw_masked;
        r_s1_mode <= bus.work_mod;
        r_s1_syn  <= w_syn;
        r_s1_par  <= w_par;
      end
    end
  end

  // Stage 2 combinational: decision and correction
  logic [2:0]                w_p;
  logic [31:0]               w_mask2;
  logic                      w_found;
  logic [4:0]                w_idx;
  logic [1:0]                w_status;
  logic [31:0]               w_cw_fix;
  logic [5:0]                w_pos;
  logic [MAX_INFO_WIDTH-1:0] w_info;

  // Locate the erroneous column and build the corrected word
  always_comb begin
    case (r_s1_mode)
      2'b00:   w_p = 3'd4;
      2'b01:   w_p = 3'd5;
      default: w_p = 3'd6;
    endcase
    w_mask2 = mask_of(r_s1_mode);
    w_found = 1'b0;
    w_idx   = 5'd0;
    for (int j = 0; j < MAX_CODEWORD_WIDTH; j++) begin
      if (w_mask2[j] && !w_found && (col_of(r_s1_mode, j) == r_s1_syn)) begin
        w_found = 1'b1;
        w_idx   = 5'(j);
      end
    end
    w_status = 2'b00;
    w_cw_fix = r_s1_cw;
    w_pos    = 6'd0;
    if (r_s1_mode == 2'b11) begin
      w_status = 2'b11;
      w_cw_fix = 32'h0;
    end else if (r_s1_syn == 5'd0) begin
      if (r_s1_par) begin
        // Only the overall parity bit itself is wrong.
        w_status = 2'b01;
        w_cw_fix = r_s1_cw ^ (32'd1 << (w_p - 3'd1));
        w_pos    = {3'b000, w_p - 3'd1};
      end
    end else if (r_s1_par && w_found) begin
      w_status = 2'b01;
      w_cw_fix = r_s1_cw ^ (32'd1 << w_idx);
      w_pos    = {1'b0, w_idx};
    end else begin
      // Even parity with nonzero syndrome: two bits flipped, pass raw word.
      w_status = 2'b10;
    end
    w_info = MAX_INFO_WIDTH'(w_cw_fix >> w_p);
  end

  logic                      r_out_valid;
  logic [MAX_INFO_WIDTH-1:0] r_info;
  logic [31:0]               r_cw;
  logic [1:0]                r_status;
  logic [5:0]                r_pos;
  logic [CNT_WIDTH-1:0]      r_corr;
  logic [CNT_WIDTH-1:0]      r_uncorr;

  // Stage 2 output registers; data holds while no word arrives
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_info      <= '0;
      r_cw        <= 32'h0;
      r_status    <= 2'b00;
      r_pos       <= 6'd0;
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_info   <= w_info;
        r_cw     <= w_cw_fix;
        r_status <= w_status;
        r_pos    <= w_pos;
      end
    end
  end

  // Saturating event counters, updated together with the outputs they count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_corr   <= '0;
      r_uncorr <= '0;
    end else if (bus.cnt_clr) begin
      r_corr   <= '0;
      r_uncorr <= '0;
    end else if (r_s1_valid) begin
      if (w_status == 2'b01 && r_corr != {CNT_WIDTH{1'b1}}) begin
        r_corr <= r_corr + 1'b1;
      end
      if (w_status == 2'b10 && r_uncorr != {CNT_WIDTH{1'b1}}) begin
        r_uncorr <= r_uncorr + 1'b1;
      end
    end
  end

  assign bus.out_valid    = r_out_valid;
  assign bus.info_out     = r_info;
  assign bus.codeword_out = r_cw;
  assign bus.status       = r_status;
  assign bus.err_pos      = r_pos;
  assign bus.corr_cnt     = r_corr;
  assign bus.uncorr_cnt   = r_uncorr;

endmodule

// File: tb/tb_secded_decoder.sv
// Directed bench for secded_decoder: a driver pushes hand-computed expected
// responses into a queue, an independent monitor pops and compares them.
module tb_secded_decoder;
  localparam int CW  = 4;
  localparam int EW  = 26 + 32 + 2 + 6 + 2 * CW;
  localparam int SAT = (1 << CW) - 1;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  secded_decoder_if #(.CNT_WIDTH(CW)) bus ();
  secded_decoder #(.CNT_WIDTH(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int m_corr = 0;
  int m_uncorr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: push the expected response, then present the word for one cycle.
  task automatic issue(input logic [31:0] cw, input logic [1:0] mode,
                       input logic [25:0] e_info, input logic [31:0] e_cw,
                       input logic [1:0] e_st, input logic [5:0] e_pos,
                       input bit clr_after);
    logic [CW-1:0] ec, eu;
    if (e_st == 2'b01 && m_corr < SAT) m_corr++;
    if (e_st == 2'b10 && m_uncorr < SAT) m_uncorr++;
    if (clr_after) begin
      m_corr = 0;
      m_uncorr = 0;
    end
    ec = CW'(m_corr);
    eu = CW'(m_uncorr);
    exp_q.push_back({e_info, e_cw, e_st, e_pos, ec, eu});
    bus.in_valid    = 1'b1;
    bus.codeword_in = cw;
    bus.work_mod    = mode;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (clr_after) begin
      bus.cnt_clr = 1'b1;
      @(posedge clk); #1;
      bus.cnt_clr = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out got=out_valid want=idle at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("info_out",     32'(bus.info_out),     32'(e[EW-1 -: 26]));
        chk("codeword_out", bus.codeword_out,      e[EW-27 -: 32]);
        chk("status",       32'(bus.status),       32'(e[EW-59 -: 2]));
        chk("err_pos",      32'(bus.err_pos),      32'(e[EW-61 -: 6]));
        chk("corr_cnt",     32'(bus.corr_cnt),     32'(e[2*CW-1 -: CW]));
        chk("uncorr_cnt",   32'(bus.uncorr_cnt),   32'(e[CW-1 -: CW]));
      end
    end
  end

  initial begin
    bus.in_valid    = 1'b0;
    bus.codeword_in = 32'h0;
    bus.work_mod    = 2'b00;
    bus.cnt_clr     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_info",      32'(bus.info_out), 32'h0);
    chk("rst_codeword",  bus.codeword_out, 32'h0);
    chk("rst_status",    32'(bus.status), 32'h0);
    chk("rst_err_pos",   32'(bus.err_pos), 32'h0);
    chk("rst_corr",      32'(bus.corr_cnt), 32'h0);
    chk("rst_uncorr",    32'(bus.uncorr_cnt), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, back-to-back
    issue(32'h0000_0087, 2'b00, 26'h8, 32'h0000_0087, 2'b00, 6'd0,  1'b0);
    issue(32'h0000_00A7, 2'b00, 26'h8, 32'h0000_0087, 2'b01, 6'd5,  1'b0);
    issue(32'h0000_008F, 2'b00, 26'h8, 32'h0000_0087, 2'b01, 6'd3,  1'b0);
    issue(32'h0000_00B7, 2'b00, 26'hB, 32'h0000_00B7, 2'b10, 6'd0,  1'b0);
    issue(32'h8000_0000, 2'b10, 26'h0, 32'h0000_0000, 2'b01, 6'd31, 1'b0);
    issue(32'h1234_5678, 2'b11, 26'h0, 32'h0000_0000, 2'b11, 6'd0,  1'b0);
    issue(32'hFFFF_0000, 2'b01, 26'h0, 32'h0000_0000, 2'b00, 6'd0,  1'b0);
    issue(32'h0000_0001, 2'b01, 26'h0, 32'h0000_0000, 2'b01, 6'd0,  1'b0);
    issue(32'h0000_0003, 2'b10, 26'h0, 32'h0000_0003, 2'b10, 6'd0,  1'b0);
    issue(32'h0000_0040, 2'b10, 26'h0, 32'h0000_0000, 2'b01, 6'd6,  1'b0);
    issue(32'h0000_0033, 2'b01, 26'h1, 32'h0000_0033, 2'b00, 6'd0,  1'b0);
    issue(32'h0000_1033, 2'b01, 26'h1, 32'h0000_0033, 2'b01, 6'd12, 1'b0);
    drain();

    // Saturation of corr_cnt
    for (int i = 0; i < 20; i++) begin
      issue(32'h0000_00A7, 2'b00, 26'h8, 32'h0000_0087, 2'b01, 6'd5, 1'b0);
    end
    drain();
    @(negedge clk);
    chk("corr_saturated", 32'(bus.corr_cnt), 32'(SAT));

    // Clear together with an increment, then counting resumes from zero
    issue(32'h0000_00A7, 2'b00, 26'h8, 32'h0000_0087, 2'b01, 6'd5, 1'b1);
    issue(32'h0000_00B7, 2'b00, 26'hB, 32'h0000_00B7, 2'b10, 6'd0, 1'b0);
    drain();

    // Reset mid-stream: both in-flight words must vanish
    issue(32'h0000_0087, 2'b00, 26'h8, 32'h0000_0087, 2'b00, 6'd0, 1'b0);
    issue(32'h0000_00A7, 2'b00, 26'h8, 32'h0000_0087, 2'b01, 6'd5, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    m_corr = 0;
    m_uncorr = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_out_valid", 32'(bus.out_valid), 32'h0);
    end
    chk("post_rst_corr", 32'(bus.corr_cnt), 32'h0);
    @(posedge clk); #1;
    issue(32'h0000_008F, 2'b00, 26'h8, 32'h0000_0087, 2'b01, 6'd3, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
